// File: rtl/axil_ctrl_master.sv
// Host command to AXI-lite bridge: single outstanding write/read, optional poll-until-mask (AXIL_POLL_EN).
// Latency accept->rsp_vld: 3 edges write, 4 edges read; cmd_rdy only in IDLE, rsp held until rsp_rdy.
module axil_ctrl_master #(
   parameter int pADDR_WIDTH = 32,
   parameter int pDATA_WIDTH = 32,
   parameter int POLL_MAX    = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   cmd_vld,
   output logic                   cmd_rdy,
   input  logic                   cmd_wr,
   input  logic                   cmd_poll,
   input  logic [pADDR_WIDTH-1:0] cmd_addr,
   input  logic [pDATA_WIDTH-1:0] cmd_wdata,
   output logic                   rsp_vld,
   input  logic                   rsp_rdy,
   output logic [pDATA_WIDTH-1:0] rsp_dat,
   output logic                   rsp_err,
   output logic                   awvalid,
   output logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   awready,
   output logic                   wvalid,
   output logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   wready,
   output logic                   arvalid,
   output logic [pADDR_WIDTH-1:0] araddr,
   input  logic                   arready,
   input  logic                   rvalid,
   input  logic [pDATA_WIDTH-1:0] rdata,
   output logic                   rready
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RA, S_RD, S_GAP, S_RSP} state_t;

   state_t state;
   logic   aw_done;
   logic   w_done;
   logic   rd_done;

`ifdef AXIL_POLL_EN
   localparam logic [7:0] POLL_LAST = 8'(POLL_MAX);
   logic                   poll_q;
   logic [pDATA_WIDTH-1:0] mask_q;
   logic [7:0]             poll_cnt;
`else
   localparam int unused_poll_max = POLL_MAX;
   logic unused_poll;
   assign unused_poll = cmd_poll;
   assign rsp_err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= S_IDLE;
         cmd_rdy <= 1'b0;
         rsp_vld <= 1'b0;
         rsp_dat <= '0;
         awvalid <= 1'b0;
         awaddr  <= '0;
         wvalid  <= 1'b0;
         wdata   <= '0;
         arvalid <= 1'b0;
         araddr  <= '0;
         rready  <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         rd_done <= 1'b0;
`ifdef AXIL_POLL_EN
         rsp_err  <= 1'b0;
         poll_q   <= 1'b0;
         mask_q   <= '0;
         poll_cnt <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               cmd_rdy <= 1'b1;
               if (cmd_vld && cmd_rdy) begin
                  cmd_rdy <= 1'b0;
`ifdef AXIL_POLL_EN
                  rsp_err  <= 1'b0;
                  poll_q   <= cmd_poll && !cmd_wr;
                  mask_q   <= cmd_wdata;
                  poll_cnt <= '0;
`endif
                  if (cmd_wr) begin
                     state   <= S_WR;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     awaddr  <= cmd_addr;
                     wdata   <= cmd_wdata;
                     aw_done <= 1'b0;
                     w_done  <= 1'b0;
                  end else begin
                     state   <= S_RA;
                     arvalid <= 1'b1;
                     araddr  <= cmd_addr;
                  end
               end
            end
            S_WR: begin
               // aw and w complete independently; exit only once both are recorded
               if (awvalid && awready) begin
                  awvalid <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (wvalid && wready) begin
                  wvalid <= 1'b0;
                  w_done <= 1'b1;
               end
               if (aw_done && w_done) begin
                  state   <= S_RSP;
                  rsp_vld <= 1'b1;
                  rsp_dat <= '0;
               end
            end
            S_RA: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  rd_done <= 1'b0;
                  state   <= S_RD;
               end
            end
            S_RD: begin
               if (!rd_done) begin
                  if (rvalid) begin
                     rsp_dat <= rdata;
                     rready  <= 1'b0;
                     rd_done <= 1'b1;
`ifdef AXIL_POLL_EN
                     poll_cnt <= poll_cnt + 8'd1;
`endif
                  end
               end else begin
`ifdef AXIL_POLL_EN
                  // a match on the final permitted read still counts as success
                  if (poll_q && (rsp_dat & mask_q) == '0) begin
                     if (poll_cnt == POLL_LAST) begin
                        state   <= S_RSP;
                        rsp_vld <= 1'b1;
                        rsp_err <= 1'b1;
                     end else begin
                        state <= S_GAP;
                     end
                  end else begin
                     state   <= S_RSP;
                     rsp_vld <= 1'b1;
                     rsp_err <= 1'b0;
                  end
`else
                  state   <= S_RSP;
                  rsp_vld <= 1'b1;
`endif
               end
            end
            S_GAP: begin
               state   <= S_RA;
               arvalid <= 1'b1;
            end
            S_RSP: begin
               if (rsp_rdy) begin
                  rsp_vld <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_ctrl_master.sv
// Randomized bench for axil_ctrl_master: slave model with random ready/valid delays, transaction-level reference.
module tb_axil_ctrl_master;

   localparam int POLL_N = 4;
`ifdef AXIL_POLL_EN
   localparam bit POLL_ON = 1'b1;
`else
   localparam bit POLL_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cmd_vld = 1'b0, cmd_rdy, cmd_wr = 1'b0, cmd_poll = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic        rsp_vld, rsp_rdy = 1'b0, rsp_err;
   logic [31:0] rsp_dat;
   logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
   logic [31:0] awaddr, wdata, araddr;
   logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
   logic [31:0] rdata = '0;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [31:0] rq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axil_ctrl_master #(.pADDR_WIDTH(32), .pDATA_WIDTH(32), .POLL_MAX(POLL_N)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr), .cmd_poll(cmd_poll),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wready(wready),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rready(rready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One command end to end. Edge index convention: at a negedge, cyc is the index of the last posedge.
   task automatic do_txn(input string name, input bit wr, input bit poll,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int aw_d, input int w_d, input int ar_d, input int r_d,
                         input int rsp_d, input int exp_lat);
      int exp_reads, aw_cnt, w_cnt, ar_cnt, r_cnt;
      int aw_age, w_age, ar_age, r_age, rsp_age;
      int acc_k, last_hs, last_r, first_rsp, proto_bad, gap_bad, rsp_bad, n;
      bit aw_pend, w_pend, ar_pend, prev_arv, done;
      logic [31:0] exp_dat, first_dat;
      logic        exp_err, first_err;

      // reference: what the transaction must produce
      exp_reads = 0; exp_dat = '0; exp_err = 1'b0;
      if (!wr) begin
         if (poll && POLL_ON) begin
            exp_err = 1'b1;
            for (int i = 0; i < POLL_N; i++) begin
               exp_reads++;
               exp_dat = rq[i];
               if ((rq[i] & wd) != 0) begin
                  exp_err = 1'b0;
                  break;
               end
            end
         end else begin
            exp_reads = 1;
            exp_dat   = rq[0];
         end
      end

      cmd_vld = 1'b1; cmd_wr = wr; cmd_poll = poll; cmd_addr = addr; cmd_wdata = wd;
      n = 0;
      while (!cmd_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_rdy) begin
         chk({name, ".accept_timeout"}, 32'(cmd_rdy), 32'd1);
         cmd_vld = 1'b0;
         return;
      end
      @(negedge clk);
      cmd_vld = 1'b0;
      acc_k = cyc;

      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_age = 0; w_age = 0; ar_age = 0; r_age = 0; rsp_age = 0;
      last_hs = acc_k; last_r = -1; first_rsp = -1;
      proto_bad = 0; gap_bad = 0; rsp_bad = 0;
      aw_pend = 0; w_pend = 0; ar_pend = 0; prev_arv = 0; done = 0;
      first_dat = '0; first_err = 1'b0;

      for (int t = 0; t < 300 && !done; t++) begin
         if (t == 0)
            chk({name, ".first_valids"}, 32'({awvalid, wvalid, arvalid}), wr ? 32'd6 : 32'd1);
         if (cmd_rdy) proto_bad++;
         if (wr ? arvalid : (awvalid || wvalid)) proto_bad++;
         if ((aw_pend && !awvalid) || (w_pend && !wvalid) || (ar_pend && !arvalid)) proto_bad++;
         if ((awvalid && awaddr !== addr) || (wvalid && wdata !== wd) || (arvalid && araddr !== addr))
            proto_bad++;
         // a new read address after a non-matching poll read: one evaluation cycle plus one GAP cycle
         if (arvalid && !prev_arv && last_r >= 0 && cyc - last_r != 2) gap_bad++;
         prev_arv = arvalid;
         if (rsp_vld) begin
            if (first_rsp < 0) begin
               first_rsp = cyc;
               first_dat = rsp_dat;
               first_err = rsp_err;
            end
            if (rsp_dat !== exp_dat || rsp_err !== exp_err) rsp_bad++;
         end

         awready = awvalid && aw_age >= aw_d;  aw_age  = awvalid ? aw_age + 1 : 0;
         wready  = wvalid && w_age >= w_d;     w_age   = wvalid ? w_age + 1 : 0;
         arready = arvalid && ar_age >= ar_d;  ar_age  = arvalid ? ar_age + 1 : 0;
         rvalid  = rready && r_age >= r_d;     r_age   = rready ? r_age + 1 : 0;
         rdata   = rvalid ? ((r_cnt < rq.size()) ? rq[r_cnt] : 32'hdead_0000) : $urandom;
         rsp_rdy = rsp_vld && rsp_age >= rsp_d; rsp_age = rsp_vld ? rsp_age + 1 : 0;
         cmd_vld = 1'($urandom % 2);

         aw_pend = awvalid && !awready;
         w_pend  = wvalid && !wready;
         ar_pend = arvalid && !arready;
         if (awvalid && awready) begin aw_cnt++; last_hs = cyc + 1; end
         if (wvalid && wready)   begin w_cnt++;  last_hs = cyc + 1; end
         if (arvalid && arready) ar_cnt++;
         if (rvalid && rready)   begin r_cnt++; last_hs = cyc + 1; last_r = cyc + 1; end
         if (rsp_vld && rsp_rdy) done = 1;
         @(negedge clk);
      end
      cmd_vld = 1'b0; awready = 0; wready = 0; arready = 0; rvalid = 0; rsp_rdy = 0;

      chk({name, ".done"}, 32'(done), 32'd1);
      chk({name, ".rsp_drop"}, 32'(rsp_vld), 32'd0);
      chk({name, ".aw_n"}, 32'(aw_cnt), wr ? 32'd1 : 32'd0);
      chk({name, ".w_n"}, 32'(w_cnt), wr ? 32'd1 : 32'd0);
      chk({name, ".ar_n"}, 32'(ar_cnt), 32'(exp_reads));
      chk({name, ".r_n"}, 32'(r_cnt), 32'(exp_reads));
      chk({name, ".rsp_dat"}, first_dat, exp_dat);
      chk({name, ".rsp_err"}, 32'(first_err), 32'(exp_err));
      chk({name, ".rsp_hold"}, 32'(rsp_bad), 32'd0);
      chk({name, ".proto"}, 32'(proto_bad), 32'd0);
      chk({name, ".gap"}, 32'(gap_bad), 32'd0);
      // response becomes visible one cycle after the final AXI handshake edge
      chk({name, ".lat_hs"}, 32'(first_rsp - last_hs), 32'd1);
      // latency counted in rising edges from acceptance to the edge that first samples rsp_vld
      if (exp_lat > 0)
         chk({name, ".lat"}, 32'(first_rsp + 1 - acc_k), 32'(exp_lat));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          wr, poll, seen;
      logic [31:0] addr, wd, v;
      int          n;

      repeat (3) @(negedge clk);
      chk("reset.ctl", 32'({cmd_rdy, rsp_vld, rsp_err, awvalid, wvalid, arvalid, rready}), 32'd0);
      chk("reset.dat", rsp_dat | awaddr | wdata | araddr, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("reset.cmd_rdy", 32'(cmd_rdy), 32'd1);

      rq.delete(); repeat (4) rq.push_back(32'h0);
      do_txn("wr_fast", 1, 0, 32'h0, 32'h1, 0, 0, 0, 0, 0, 3);
      do_txn("wr_wlate", 1, 0, 32'h8, 32'hCAFE_0001, 0, 3, 0, 0, 1, 0);
      rq.delete(); rq.push_back(32'h0000_ABCD); repeat (3) rq.push_back(32'h0);
      do_txn("rd_slow", 0, 0, 32'h10, 32'h0, 0, 0, 0, 2, 0, 0);
      do_txn("rd_fast", 0, 0, 32'h14, 32'h0, 0, 0, 0, 0, 0, 4);

      rq.delete(); rq.push_back(32'h4); rq.push_back(32'h4); rq.push_back(32'h6); rq.push_back(32'h4);
      do_txn("poll_hit3", 0, 1, 32'h0, 32'h2, 0, 0, 1, 1, 0, 0);
      rq.delete(); repeat (4) rq.push_back(32'h4);
      do_txn("poll_tmo", 0, 1, 32'h0, 32'h2, 0, 0, 0, 0, 2, 0);
      rq.delete(); repeat (3) rq.push_back(32'h4); rq.push_back(32'h2);
      do_txn("poll_last", 0, 1, 32'h20, 32'h2, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         wr   = 1'($urandom % 2);
         poll = 1'($urandom % 2);
         addr = $urandom & 32'h0000_FFFC;
         wd   = $urandom;
         if (poll && !wr) wd = 32'h1 << $urandom_range(0, 31);
         rq.delete();
         for (int j = 0; j < 4; j++) begin
            v = $urandom & ~wd;
            if ($urandom % 3 == 0) v = v | wd;
            rq.push_back(v);
         end
         do_txn("rnd", wr, poll, addr, wd, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end

      // reset while a read address is outstanding
      n = 0;
      while (!cmd_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_poll = 1'b0; cmd_addr = 32'h44; arready = 1'b0; rsp_rdy = 1'b0;
      @(negedge clk);
      cmd_vld = 1'b0;
      chk("rst_mid.arvalid", 32'(arvalid), 32'd1);
      rstn = 1'b0;
      @(negedge clk);
      chk("rst_mid.ctl", 32'({cmd_rdy, rsp_vld, rsp_err, awvalid, wvalid, arvalid, rready}), 32'd0);
      chk("rst_mid.dat", rsp_dat | awaddr | wdata | araddr, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_mid.cmd_rdy", 32'(cmd_rdy), 32'd1);
      seen = 0;
      repeat (5) begin
         if (rsp_vld || arvalid) seen = 1;
         @(negedge clk);
      end
      chk("rst_mid.quiet", 32'(seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
